// File: rtl/mod_counter_pkg.sv
// Shared constants and helpers for the modulo counter family.
// Instantiating blocks size their count buses with clog2.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

  localparam bit   MODE_WRAP = 1'b0;
  localparam bit   MODE_SAT  = 1'b1;

  // Which rule wins on a given edge: load beats count, count beats hold.
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_COUNT = 2'd1,
    ACT_LOAD  = 2'd2
  } act_e;

  // Bits needed to hold the values 0..value-1 (minimum 1).
  function automatic int clog2(input longint unsigned value);
    int bits;
    longint unsigned span;
    bits = 0;
    span = 1;
    while (span < value) begin
      span = span << 1;
      bits++;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/mod_counter_if.sv
// Control and status bundle of mod_counter; the user drives the master side.
interface mod_counter_if #(
  parameter int WIDTH = 4
);

  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             sat;
  logic             load_err;

  modport master (
    output en, up, load, load_val,
    input  q, tc, wrap, sat, load_err
  );

  modport slave (
    input  en, up, load, load_val,
    output q, tc, wrap, sat, load_err
  );

endinterface

// File: rtl/mod_counter.sv
// Parametrised up/down modulo counter with load, wrap/saturate modes,
// terminal-count, wrap pulse, saturation level and sticky load-range error.
module mod_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter bit              SATURATE = MODE_WRAP
) (
  input  logic         clk,
  input  logic         reset,
  mod_counter_if.slave bus
);

  localparam longint unsigned MOD_LIMIT = 64'd1 << WIDTH;
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 64'd1);

  if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || MODULUS > MOD_LIMIT) begin : g_bad_params
    $error("mod_counter: illegal WIDTH/MODULUS combination");
  end

  logic [WIDTH-1:0] q_r, q_nx;
  logic             wrap_r, wrap_nx;
  logic             sat_r, sat_nx;
  logic             err_r, err_nx;
  logic             at_max, at_min, boundary;
  act_e             act;

  assign at_max   = (q_r == MAX_VAL);
  assign at_min   = (q_r == '0);
  assign boundary = (bus.up == DIR_UP) ? at_max : at_min;

  always_comb begin
    act = ACT_HOLD;
    if (bus.load)
      act = ACT_LOAD;
    else if (bus.en)
      act = ACT_COUNT;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    q_nx    = q_r;
    wrap_nx = 1'b0;
    sat_nx  = sat_r;
    err_nx  = err_r;
    unique case (act)
      ACT_LOAD: begin
        sat_nx = 1'b0;
        if (bus.load_val > MAX_VAL) begin
          q_nx   = MAX_VAL;
          err_nx = 1'b1;
        end else begin
          q_nx = bus.load_val;
        end
      end
      ACT_COUNT: begin
        if (boundary) begin
          if (SATURATE == MODE_SAT) begin
            sat_nx = 1'b1;
          end else begin
            wrap_nx = 1'b1;
            q_nx    = (bus.up == DIR_UP) ? '0 : MAX_VAL;
          end
        end else begin
          // Any count that moves q leaves the boundary, so saturation ends.
          sat_nx = 1'b0;
          q_nx   = (bus.up == DIR_UP) ? q_r + 1'b1 : q_r - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
      sat_r  <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      q_r    <= q_nx;
      wrap_r <= wrap_nx;
      sat_r  <= sat_nx;
      err_r  <= err_nx;
    end
  end

  assign bus.q        = q_r;
  assign bus.wrap     = wrap_r;
  assign bus.sat      = sat_r;
  assign bus.load_err = err_r;
  assign bus.tc       = (act == ACT_COUNT) && boundary;

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: four configurations share one stimulus
// stream and are compared against an integer reference model.
module tb_mod_counter;

  typedef struct {
    int tc;
    int q;
    int wrap;
    int sat;
    int err;
  } exp_t;

  localparam int NDUT = 4;

  logic       clk;
  logic       reset;
  logic       en_s, up_s, load_s;
  logic [3:0] lv_s;

  logic [3:0] q_o    [NDUT];
  logic       tc_o   [NDUT];
  logic       wrap_o [NDUT];
  logic       sat_o  [NDUT];
  logic       err_o  [NDUT];

  int n_chk;
  int n_err;

  exp_t sb [NDUT][$];

  int m_q    [NDUT];
  int m_wrap [NDUT];
  int m_sat  [NDUT];
  int m_err  [NDUT];

  // Configurations: A wrap mod 10, B saturate mod 10, C natural mod 16, D 1-bit mod 2.
  function automatic int cfg_mod(input int d);
    case (d)
      0, 1:    return 10;
      2:       return 16;
      default: return 2;
    endcase
  endfunction

  function automatic int cfg_sat(input int d);
    return (d == 1) ? 1 : 0;
  endfunction

  function automatic int cfg_width(input int d);
    return (d == 3) ? 1 : 4;
  endfunction

  mod_counter_if #(.WIDTH(4)) if_a ();
  mod_counter_if #(.WIDTH(4)) if_b ();
  mod_counter_if #(.WIDTH(4)) if_c ();
  mod_counter_if #(.WIDTH(1)) if_d ();

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
  mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) dut_c (.clk(clk), .reset(reset), .bus(if_c));
  mod_counter #(.WIDTH(1), .MODULUS(2),  .SATURATE(1'b0)) dut_d (.clk(clk), .reset(reset), .bus(if_d));

  assign if_a.en = en_s;  assign if_a.up = up_s;  assign if_a.load = load_s;  assign if_a.load_val = lv_s;
  assign if_b.en = en_s;  assign if_b.up = up_s;  assign if_b.load = load_s;  assign if_b.load_val = lv_s;
  assign if_c.en = en_s;  assign if_c.up = up_s;  assign if_c.load = load_s;  assign if_c.load_val = lv_s;
  assign if_d.en = en_s;  assign if_d.up = up_s;  assign if_d.load = load_s;  assign if_d.load_val = lv_s[0];

  assign q_o[0] = if_a.q;           assign tc_o[0] = if_a.tc;  assign wrap_o[0] = if_a.wrap;
  assign q_o[1] = if_b.q;           assign tc_o[1] = if_b.tc;  assign wrap_o[1] = if_b.wrap;
  assign q_o[2] = if_c.q;           assign tc_o[2] = if_c.tc;  assign wrap_o[2] = if_c.wrap;
  assign q_o[3] = {3'b000, if_d.q}; assign tc_o[3] = if_d.tc;  assign wrap_o[3] = if_d.wrap;
  assign sat_o[0] = if_a.sat;  assign err_o[0] = if_a.load_err;
  assign sat_o[1] = if_b.sat;  assign err_o[1] = if_b.load_err;
  assign sat_o[2] = if_c.sat;  assign err_o[2] = if_c.load_err;
  assign sat_o[3] = if_d.sat;  assign err_o[3] = if_d.load_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      m_q[d] = 0; m_wrap[d] = 0; m_sat[d] = 0; m_err[d] = 0;
    end
  endtask

  // Drive one cycle of stimulus and push the expected response of every DUT.
  task automatic step(input logic e, input logic u, input logic l, input logic [3:0] v);
    exp_t x;
    int   md, lvd, nxt;
    @(negedge clk);
    en_s = e; up_s = u; load_s = l; lv_s = v;
    for (int d = 0; d < NDUT; d++) begin
      md   = cfg_mod(d);
      lvd  = int'(v) % (1 << cfg_width(d));
      x.tc = (e && !l && ((u && m_q[d] == md - 1) || (!u && m_q[d] == 0))) ? 1 : 0;
      if (l) begin
        if (lvd >= md) begin
          m_q[d]   = md - 1;
          m_err[d] = 1;
        end else begin
          m_q[d] = lvd;
        end
        m_wrap[d] = 0;
        m_sat[d]  = 0;
      end else if (e) begin
        nxt = u ? m_q[d] + 1 : m_q[d] - 1;
        if (nxt < 0 || nxt >= md) begin
          if (cfg_sat(d) == 1) begin
            m_sat[d]  = 1;
            m_wrap[d] = 0;
          end else begin
            m_q[d]    = (nxt + md) % md;
            m_wrap[d] = 1;
          end
        end else begin
          m_q[d]    = nxt;
          m_wrap[d] = 0;
          m_sat[d]  = 0;
        end
      end else begin
        m_wrap[d] = 0;
      end
      x.q = m_q[d]; x.wrap = m_wrap[d]; x.sat = m_sat[d]; x.err = m_err[d];
      sb[d].push_back(x);
    end
  endtask

  task automatic check_cleared(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("%s q[%0d]", tag, d), int'(q_o[d]), 0);
      check($sformatf("%s wrap[%0d]", tag, d), int'(wrap_o[d]), 0);
      check($sformatf("%s sat[%0d]", tag, d), int'(sat_o[d]), 0);
      check($sformatf("%s load_err[%0d]", tag, d), int'(err_o[d]), 0);
    end
  endtask

  // Monitor: tc is compared mid-cycle, registered outputs just after the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      for (int d = 0; d < NDUT; d++)
        if (sb[d].size() > 0)
          check($sformatf("tc[%0d]", d), int'(tc_o[d]), sb[d][0].tc);
      @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
        if (sb[d].size() > 0) begin
          e = sb[d].pop_front();
          check($sformatf("q[%0d]", d), int'(q_o[d]), e.q);
          check($sformatf("wrap[%0d]", d), int'(wrap_o[d]), e.wrap);
          check($sformatf("sat[%0d]", d), int'(sat_o[d]), e.sat);
          check($sformatf("load_err[%0d]", d), int'(err_o[d]), e.err);
        end
      end
    end
  end

  initial begin : stimulus
    n_chk = 0;
    n_err = 0;
    en_s = 1'b0; up_s = 1'b0; load_s = 1'b0; lv_s = 4'd0;
    reset = 1'b1;
    model_reset();
    #2;
    check_cleared("reset");
    for (int d = 0; d < NDUT; d++)
      check($sformatf("reset tc[%0d]", d), int'(tc_o[d]), 0);
    #15;
    reset = 1'b0;

    repeat (12) step(1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b0, 1'b1, 4'd3);
    repeat (5) step(1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b1, 4'd8);
    repeat (4) step(1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 1'b1, 4'd12);
    step(1'b0, 1'b0, 1'b1, 4'd2);
    repeat (3) step(1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b1, 4'd5);
    repeat (3) step(1'b0, 1'b1, 1'b0, 4'd0);
    repeat (2) step(1'b1, 1'b1, 1'b0, 4'd0);

    // Asynchronous reset in the middle of a cycle while counting.
    @(posedge clk);
    #3;
    en_s = 1'b0; load_s = 1'b0;
    reset = 1'b1;
    #1;
    check_cleared("async reset");
    #9;
    reset = 1'b0;
    model_reset();
    repeat (3) step(1'b1, 1'b1, 1'b0, 4'd0);

    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));

    repeat (2) @(posedge clk);
    #3;
    for (int d = 0; d < NDUT; d++)
      check($sformatf("drain[%0d]", d), sb[d].size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
